// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep controller.
// No logic of its own; the golden table lives here so ctrl and bench agree.
// Not applicable (package only).
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 4;

    // Bit positions of each gate inside gate_out.
    localparam int AND_BIT  = 5;
    localparam int OR_BIT   = 4;
    localparam int NAND_BIT = 3;
    localparam int NOR_BIT  = 2;
    localparam int XOR_BIT  = 1;
    localparam int XNOR_BIT = 0;

    localparam logic [5:0] GOLDEN_V0 = 6'b001101;
    localparam logic [5:0] GOLDEN_V1 = 6'b011010;
    localparam logic [5:0] GOLDEN_V2 = 6'b011010;
    localparam logic [5:0] GOLDEN_V3 = 6'b110001;

    function automatic logic [5:0] golden_vector(input logic [1:0] k);
        logic [5:0] g;
        case (k)
            2'd0:    g = GOLDEN_V0;
            2'd1:    g = GOLDEN_V1;
            2'd2:    g = GOLDEN_V2;
            default: g = GOLDEN_V3;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/gate_sweep_timer.sv
// Settle counter: expire is high on the last cycle of each settle window.
// Latency: expire every SETTLE_CYCLES cycles while clear is low.
// Backpressure: none; clear holds the count at zero.
module gate_sweep_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expire
);

    localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

    logic [3:0] cnt_q;

    assign expire = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || expire) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps gate block A/B through 00,01,10,11 and captures the six outputs; GATE_SWEEP_CHECK_EN adds golden checking.
// Latency: done pulses 4*SETTLE_CYCLES cycles after the start-accepting edge.
// Backpressure: start only sampled in IDLE; never queued.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        gate_a,
    output logic        gate_b,
    input  logic [5:0]  gate_out,
    output logic [23:0] result,
    output logic        pass,
    output logic [3:0]  err_vec
);

    localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

    state_t      state_q, state_d;
    logic [1:0]  vec_q, vec_d;
    logic [23:0] result_q, result_d;
    logic        expire;
    logic        timer_clear;

    assign timer_clear = (state_q != RUN);

    gate_sweep_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .expire(expire)
    );

    // AB is only driven while running; IDLE and DONE park it at 00.
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign gate_a = busy & vec_q[1];
    assign gate_b = busy & vec_q[0];
    assign result = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= 2'd0;
            result_q <= 24'd0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    vec_d    = 2'd0;
                    result_d = 24'd0;
                end
            end
            RUN: begin
                if (expire) begin
                    result_d[6*vec_q +: 6] = gate_out;
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                        vec_d   = 2'd0;
                    end else begin
                        vec_d = vec_q + 2'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef GATE_SWEEP_CHECK_EN
    logic [3:0] err_q, err_d;
    logic       pass_q, pass_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 4'd0;
            pass_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            pass_q <= pass_d;
        end
    end

    // pass folds in the final vector's own mismatch, so it uses err_d.
    always_comb begin
        err_d  = err_q;
        pass_d = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d  = 4'd0;
                    pass_d = 1'b0;
                end
            end
            RUN: begin
                if (expire) begin
                    if (gate_out != golden_vector(vec_q)) begin
                        err_d[vec_q] = 1'b1;
                    end
                    if (vec_q == LAST_VEC) begin
                        pass_d = (err_d == 4'd0);
                    end
                end
            end
            default: ;
        endcase
    end

    assign err_vec = err_q;
    assign pass    = pass_q;
`else
    assign err_vec = 4'd0;
    assign pass    = 1'b0;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl with a behavioural gate block attached.
// Covers reset, full sweep, fault injection, abort, ignored start, back-to-back and SETTLE_CYCLES=1.
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic [5:0]  fault_mask = 6'd0;

    logic        busy, done, gate_a, gate_b, pass;
    logic [5:0]  gate_out;
    logic [23:0] result;
    logic [3:0]  err_vec;

    logic        busy1, done1, gate_a1, gate_b1, pass1;
    logic [5:0]  gate_out1;
    logic [23:0] result1;
    logic [3:0]  err_vec1;

    int checks = 0;
    int failures = 0;

`ifdef GATE_SWEEP_CHECK_EN
    localparam logic       EXP_PASS_GOOD = 1'b1;
    localparam logic [3:0] EXP_ERR_FAULT = 4'b1001;
`else
    localparam logic       EXP_PASS_GOOD = 1'b0;
    localparam logic [3:0] EXP_ERR_FAULT = 4'b0000;
`endif

    always #5 clk = ~clk;

    function automatic logic [5:0] gate_model(input logic a, input logic b);
        logic [5:0] g;
        g[AND_BIT]  = a & b;
        g[OR_BIT]   = a | b;
        g[NAND_BIT] = ~(a & b);
        g[NOR_BIT]  = ~(a | b);
        g[XOR_BIT]  = a ^ b;
        g[XNOR_BIT] = ~(a ^ b);
        return g;
    endfunction

    assign gate_out  = gate_model(gate_a, gate_b) & ~fault_mask;
    assign gate_out1 = gate_model(gate_a1, gate_b1);

    gate_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .gate_a(gate_a), .gate_b(gate_b), .gate_out(gate_out),
        .result(result), .pass(pass), .err_vec(err_vec)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .gate_a(gate_a1), .gate_b(gate_b1), .gate_out(gate_out1),
        .result(result1), .pass(pass1), .err_vec(err_vec1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; returns just after the accepting edge.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Edges counted from the accepting edge until done is seen; 99 if it never comes.
    task automatic wait_done(output int n);
        n = 99;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int first_done, pulses, prev, gap_bad;

        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ab", {gate_a, gate_b}, 2'b00);
        check("rst_result", result, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_vec, 0);
        rst = 1'b0;
        tick();

        // Clean sweep.
        pulse_start();
        check("s1_busy", busy, 1);
        check("s1_ab0", {gate_a, gate_b}, 2'b00);
        tick();
        tick();
        check("s1_ab1", {gate_a, gate_b}, 2'b01);
        wait_done(n);
        check("s1_latency", n, 6);
        check("s1_result", result, 24'hC5A68D);
        check("s1_pass", pass, EXP_PASS_GOOD);
        check("s1_err", err_vec, 0);
        check("s1_busy_done", busy, 0);
        check("s1_ab_done", {gate_a, gate_b}, 2'b00);
        tick();
        check("s1_done_pulse", done, 0);
        check("s1_result_hold", result, 24'hC5A68D);
        check("s1_pass_hold", pass, EXP_PASS_GOOD);

        // XNOR stuck at 0.
        fault_mask = 6'b000001;
        pulse_start();
        wait_done(n);
        check("s2_latency", n, 8);
        check("s2_result", result, 24'hC1A68C);
        check("s2_err", err_vec, EXP_ERR_FAULT);
        check("s2_pass", pass, 0);
        fault_mask = 6'd0;
        tick();

        // Reset in the middle of a sweep.
        pulse_start();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s3_busy", busy, 0);
        check("s3_ab", {gate_a, gate_b}, 2'b00);
        check("s3_result", result, 0);
        check("s3_err", err_vec, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) pulses++;
        end
        check("s3_no_done", pulses, 0);

        // Extra start mid-run is ignored.
        pulse_start();
        pulses = 0;
        first_done = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 4) start = 1'b1;
            tick();
            start = 1'b0;
            if (done) begin
                pulses++;
                if (first_done == 0) first_done = i;
            end
        end
        check("s4_done_at", first_done, 8);
        check("s4_single_done", pulses, 1);
        check("s4_idle", busy, 0);
        check("s4_result", result, 24'hC5A68D);

        // start held high: back-to-back sweeps.
        start = 1'b1;
        pulses = 0;
        prev = 0;
        gap_bad = 0;
        first_done = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                pulses++;
                if (first_done == 0) first_done = i;
                else if (i - prev != 10) gap_bad++;
                prev = i;
                check("s5_result", result, 24'hC5A68D);
            end
        end
        start = 1'b0;
        check("s5_first", first_done, 9);
        check("s5_pulses", pulses, 4);
        check("s5_gap", gap_bad, 0);
        tick();
        tick();

        // SETTLE_CYCLES=1 instance.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("s6_ab0", {gate_a1, gate_b1}, 2'b00);
        tick();
        check("s6_ab1", {gate_a1, gate_b1}, 2'b01);
        tick();
        check("s6_ab2", {gate_a1, gate_b1}, 2'b10);
        tick();
        check("s6_ab3", {gate_a1, gate_b1}, 2'b11);
        check("s6_busy", busy1, 1);
        tick();
        check("s6_done", done1, 1);
        check("s6_ab_done", {gate_a1, gate_b1}, 2'b00);
        check("s6_result", result1, 24'hC5A68D);
        check("s6_pass", pass1, EXP_PASS_GOOD);
        check("s6_err", err_vec1, 0);
        tick();
        check("s6_done_pulse", done1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
